// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, byte-addressed, 32-bit little-endian memory between
// instruction fetch (IF) and load/store (LS). Each access runs through a small
// FSM:
//   IF read / LS load : IDLE -> RD -> RESP -> IDLE
//   LS word store     : IDLE -> WR -> RESP -> IDLE
//   LS byte/half store: IDLE -> RMW_RD -> RMW_MRG -> WR -> RESP -> IDLE
//   LS bad access     : IDLE -> RESP -> IDLE (ls_err, memory untouched)
//
// The memory samples mem_address on the clock edge and returns mem_data_out in
// the following cycle. mem_read_write=1 writes mem_data_in on the edge that
// ends the WR state.
//
// Optional feature: define ARB_STARVE_GUARD_EN to add an IF starvation guard.
// After MAX_STARVE consecutive LS grants taken while IF was waiting, IF wins
// the next IDLE cycle in which both request. Without the macro LS always wins.
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (word read) and byte address
//   if_gnt                fetch accepted this cycle (combinational, IDLE only)
//   if_done/if_rdata      1-cycle completion pulse, fetched word (held)
//   ls_req/ls_we/ls_size  load/store request, 1=store, 00/01/10 byte/half/word
//   ls_unsigned           zero-extend loads when 1, sign-extend when 0
//   ls_addr/ls_wdata      byte address, right-aligned store data
//   ls_gnt                LS accepted this cycle (combinational, IDLE only)
//   ls_done/ls_rdata      1-cycle completion pulse, extended load data (held)
//   ls_err                with ls_done: misaligned / illegal size, no access
//   mem_address           aligned word address to memory
//   mem_read_write        1 = write on this edge (only in WR)
//   mem_data_in           write word to memory
//   mem_data_out          read word from memory
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
  parameter int          MAX_STARVE = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  // instruction fetch
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  // load / store
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  // memory
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RESP,
    WR,
    RMW_RD,
    RMW_MRG
  } state_t;

  state_t      state_reg;

  // Request captured at grant; the requester is free to drop req afterwards.
  logic        lat_is_if_reg;
  logic        lat_we_reg;
  logic [1:0]  lat_size_reg;
  logic        lat_unsigned_reg;
  logic [1:0]  lat_off_reg;
  logic [15:0] lat_wdata_reg;

  // Registered outputs
  logic        if_done_reg;
  logic        ls_done_reg;
  logic        ls_err_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] ls_rdata_reg;
  logic [31:0] mem_address_reg;
  logic        mem_read_write_reg;
  logic [31:0] mem_data_in_reg;

  // Combinational helpers
  logic        idle;
  logic        if_wins;
  logic        ls_bad;
  logic [3:0]  be_next;
  logic [31:0] lane_wdata_next;
  logic [31:0] merged_next;
  logic [7:0]  load_byte_next;
  logic [15:0] load_half_next;
  logic [31:0] load_ext_next;
  logic        ls_load_done;

  // Fetches are always whole words; the byte offset is deliberately ignored.
  logic        unused_if_addr_bits;
  assign unused_if_addr_bits = &{1'b0, if_addr[1:0]};

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign idle   = (state_reg == IDLE);
  assign ls_gnt = idle && ls_req && !if_wins;
  assign if_gnt = idle && if_req && !ls_gnt;

`ifdef ARB_STARVE_GUARD_EN
  localparam int                  STARVE_W   = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve_cnt_reg;

  // Counts LS grants taken while IF was kept waiting; saturates at the limit
  // so the override stays armed until IF actually gets through.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_reg <= '0;
    end else if (if_gnt) begin
      starve_cnt_reg <= '0;
    end else if (ls_gnt && if_req && (starve_cnt_reg != STARVE_LIM)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign if_wins = (starve_cnt_reg == STARVE_LIM) && if_req && ls_req;
`else
  assign if_wins = 1'b0;
`endif

  // Size 11 is never legal; half needs even address, word needs 4-aligned.
  assign ls_bad = (ls_size == 2'b11) ||
                  ((ls_size == SZ_HALF) && ls_addr[0]) ||
                  ((ls_size == SZ_WORD) && (ls_addr[1:0] != 2'b00));

  // -------------------------------------------------------------------------
  // Sub-word store merge: replicate store data onto every lane, then let the
  // byte enables pick which lanes come from the store and which from memory.
  // -------------------------------------------------------------------------
  always_comb begin
    be_next         = 4'b1111;
    lane_wdata_next = {2{lat_wdata_reg}};
    case (lat_size_reg)
      SZ_BYTE: begin
        be_next         = 4'b0001 << lat_off_reg;
        lane_wdata_next = {4{lat_wdata_reg[7:0]}};
      end
      SZ_HALF: begin
        be_next         = lat_off_reg[1] ? 4'b1100 : 4'b0011;
        lane_wdata_next = {2{lat_wdata_reg}};
      end
      default: begin
        be_next         = 4'b1111;
        lane_wdata_next = {2{lat_wdata_reg}};
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
      assign merged_next[8*gi +: 8] = be_next[gi] ? lane_wdata_next[8*gi +: 8]
                                                  : mem_data_out[8*gi +: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Load extraction and extension
  // -------------------------------------------------------------------------
  always_comb begin
    load_byte_next = mem_data_out[7:0];
    case (lat_off_reg)
      2'd0:    load_byte_next = mem_data_out[7:0];
      2'd1:    load_byte_next = mem_data_out[15:8];
      2'd2:    load_byte_next = mem_data_out[23:16];
      default: load_byte_next = mem_data_out[31:24];
    endcase
  end

  assign load_half_next = lat_off_reg[1] ? mem_data_out[31:16] : mem_data_out[15:0];

  always_comb begin
    load_ext_next = mem_data_out;
    case (lat_size_reg)
      SZ_BYTE: load_ext_next = {{24{~lat_unsigned_reg & load_byte_next[7]}}, load_byte_next};
      SZ_HALF: load_ext_next = {{16{~lat_unsigned_reg & load_half_next[15]}}, load_half_next};
      default: load_ext_next = mem_data_out;
    endcase
  end

  // Read data is only present on mem_data_out during RESP, so it is forwarded
  // straight through in the done cycle and captured for holding afterwards.
  assign ls_load_done = ls_done_reg && !ls_err_reg && !lat_we_reg;

  assign if_rdata = if_done_reg  ? mem_data_out  : if_rdata_reg;
  assign ls_rdata = ls_load_done ? load_ext_next : ls_rdata_reg;

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      lat_is_if_reg      <= 1'b0;
      lat_we_reg         <= 1'b0;
      lat_size_reg       <= 2'b00;
      lat_unsigned_reg   <= 1'b0;
      lat_off_reg        <= 2'b00;
      lat_wdata_reg      <= '0;
      if_done_reg        <= 1'b0;
      ls_done_reg        <= 1'b0;
      ls_err_reg         <= 1'b0;
      if_rdata_reg       <= '0;
      ls_rdata_reg       <= '0;
      mem_address_reg    <= BASE_ADDR;
      mem_read_write_reg <= 1'b0;
      mem_data_in_reg    <= '0;
    end else begin
      // Pulses default low; each state sets what it needs for the next cycle.
      if_done_reg        <= 1'b0;
      ls_done_reg        <= 1'b0;
      ls_err_reg         <= 1'b0;
      mem_read_write_reg <= 1'b0;

      if (if_done_reg) begin
        if_rdata_reg <= mem_data_out;
      end
      if (ls_load_done) begin
        ls_rdata_reg <= load_ext_next;
      end

      case (state_reg)
        IDLE: begin
          if (ls_gnt) begin
            lat_is_if_reg    <= 1'b0;
            lat_we_reg       <= ls_we;
            lat_size_reg     <= ls_size;
            lat_unsigned_reg <= ls_unsigned;
            lat_off_reg      <= ls_addr[1:0];
            lat_wdata_reg    <= ls_wdata[15:0];
            if (ls_bad) begin
              state_reg   <= RESP;
              ls_done_reg <= 1'b1;
              ls_err_reg  <= 1'b1;
            end else begin
              mem_address_reg <= {ls_addr[31:2], 2'b00};
              if (!ls_we) begin
                state_reg <= RD;
              end else if (ls_size == SZ_WORD) begin
                state_reg          <= WR;
                mem_data_in_reg    <= ls_wdata;
                mem_read_write_reg <= 1'b1;
              end else begin
                state_reg <= RMW_RD;
              end
            end
          end else if (if_gnt) begin
            lat_is_if_reg   <= 1'b1;
            lat_we_reg      <= 1'b0;
            lat_size_reg    <= SZ_WORD;
            lat_off_reg     <= 2'b00;
            mem_address_reg <= {if_addr[31:2], 2'b00};
            state_reg       <= RD;
          end
        end

        RD: begin
          state_reg <= RESP;
          if (lat_is_if_reg) begin
            if_done_reg <= 1'b1;
          end else begin
            ls_done_reg <= 1'b1;
          end
        end

        RMW_RD: begin
          state_reg <= RMW_MRG;
        end

        RMW_MRG: begin
          state_reg          <= WR;
          mem_data_in_reg    <= merged_next;
          mem_read_write_reg <= 1'b1;
        end

        WR: begin
          state_reg   <= RESP;
          ls_done_reg <= 1'b1;
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign if_done        = if_done_reg;
  assign ls_done        = ls_done_reg;
  assign ls_err         = ls_err_reg;
  assign mem_address    = mem_address_reg;
  assign mem_read_write = mem_read_write_reg;
  assign mem_data_in    = mem_data_in_reg;

endmodule
